// File: rtl/i2s_rx_pkg.sv
// Shared widths, entry type and serial-format delay for the I2S receiver.
// I2S_RX_LJ_EN selects left-justified framing (MSB on the first bclk after the lr edge).
package i2s_rx_pkg;

  localparam int SAMPLE_W = 16;
  localparam int STEREO_W = 32;

`ifdef I2S_RX_LJ_EN
  localparam int I2S_DELAY = 0;
`else
  localparam int I2S_DELAY = 1;
`endif

  typedef struct packed {
    logic                tlast;
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } fifo_entry_t;

endpackage

// File: rtl/i2s_rx_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on head_o whenever empty_o is low.
module i2s_rx_fifo
  import i2s_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        push_i,
  input  fifo_entry_t push_data_i,
  input  logic        pop_i,
  output fifo_entry_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge aclk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/i2s_rx_axis.sv
// Stereo I2S / left-justified receiver producing AXI4-Stream {L,R} words with framed tlast.
// Define I2S_RX_LJ_EN for left-justified input; default is Philips I2S.
module i2s_rx_axis
  import i2s_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_LEN  = 256
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                i2s_bclk,
  input  logic                i2s_lrclk,
  input  logic                i2s_sdata,
  input  logic                rx_enable,
  input  logic                ovf_clr,
  output logic                ovf_sticky,
  output logic [STEREO_W-1:0] m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast
);

  localparam int FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_LEN - 1);
  localparam logic [5:0] SLOT_MAX = 6'd63;
  localparam logic [5:0] DLY      = 6'(I2S_DELAY);

  // [0] first sync stage, [1] synchronised, [2] history; all three inputs share the pipeline.
  logic [2:0]          bclk_q, lr_q, sd_q;
  logic                bclk_rise, lr_s, sd_s;
  logic [5:0]          slot_pos_q, slot_pos_d, idx;
  logic                lr_prev_q, lr_prev_d, lr_chg, in_range;
  logic [15:0]         sr_q, sr_d, sr_base;
  logic [15:0]         left_hold_q, left_hold_d;
  logic                left_valid_q, left_valid_d;
  logic                push_q, push_d;
  logic [STEREO_W-1:0] pair_q, pair_d;
  logic [FCW-1:0]      frame_q, frame_d;
  logic                ovf_q, ovf_d;
  logic                push_en, pop, accept, drop;
  logic                fifo_full, fifo_empty;
  fifo_entry_t         wr_entry, head;

  assign bclk_rise = bclk_q[1] && !bclk_q[2];
  assign lr_s      = lr_q[2];
  assign sd_s      = sd_q[2];

  always_comb begin
    slot_pos_d   = slot_pos_q;
    lr_prev_d    = lr_prev_q;
    sr_d         = sr_q;
    sr_base      = sr_q;
    left_hold_d  = left_hold_q;
    left_valid_d = left_valid_q && rx_enable;
    push_d       = 1'b0;
    pair_d       = pair_q;
    lr_chg       = 1'b0;
    idx          = '0;
    in_range     = 1'b0;
    if (bclk_rise) begin
      lr_chg    = (lr_s != lr_prev_q);
      lr_prev_d = lr_s;
      if (lr_chg)                       slot_pos_d = '0;
      else if (slot_pos_q != SLOT_MAX)  slot_pos_d = slot_pos_q + 6'd1;
      idx      = slot_pos_d - DLY;
      in_range = (slot_pos_d >= DLY) && (idx <= 6'd15);
      // An lr edge abandons any partial word from a short slot.
      sr_base  = lr_chg ? '0 : sr_q;
      sr_d     = sr_base;
      if (in_range) begin
        sr_d = {sr_base[14:0], sd_s};
        if (idx == 6'd15) begin
          if (!lr_s) begin
            if (rx_enable) begin
              left_hold_d  = sr_d;
              left_valid_d = 1'b1;
            end
          end else if (left_valid_q && rx_enable) begin
            push_d       = 1'b1;
            pair_d       = {left_hold_q, sr_d};
            left_valid_d = 1'b0;
          end
        end
      end
    end
  end

  assign push_en  = push_q && rx_enable;
  assign pop      = m_axis_tvalid && m_axis_tready;
  assign accept   = push_en && (!fifo_full || pop);
  assign drop     = push_en && fifo_full && !pop;
  assign wr_entry = '{tlast: (frame_q == FRAME_LAST), l: pair_q[31:16], r: pair_q[15:0]};

  always_comb begin
    frame_d = frame_q;
    if (accept) frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
    // A drop in the same cycle as a clear keeps the flag set.
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bclk_q       <= '0;
      lr_q         <= '0;
      sd_q         <= '0;
      slot_pos_q   <= SLOT_MAX;
      lr_prev_q    <= 1'b0;
      sr_q         <= '0;
      left_hold_q  <= '0;
      left_valid_q <= 1'b0;
      push_q       <= 1'b0;
      pair_q       <= '0;
      frame_q      <= '0;
      ovf_q        <= 1'b0;
    end else begin
      bclk_q       <= {bclk_q[1:0], i2s_bclk};
      lr_q         <= {lr_q[1:0], i2s_lrclk};
      sd_q         <= {sd_q[1:0], i2s_sdata};
      slot_pos_q   <= slot_pos_d;
      lr_prev_q    <= lr_prev_d;
      sr_q         <= sr_d;
      left_hold_q  <= left_hold_d;
      left_valid_q <= left_valid_d;
      push_q       <= push_d;
      pair_q       <= pair_d;
      frame_q      <= frame_d;
      ovf_q        <= ovf_d;
    end
  end

  i2s_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .push_i      (accept),
    .push_data_i (wr_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = m_axis_tvalid ? {head.l, head.r} : '0;
  assign m_axis_tlast  = m_axis_tvalid && head.tlast;
  assign ovf_sticky    = ovf_q;

endmodule

// File: tb/tb_i2s_rx_axis.sv
// Scoreboard bench for i2s_rx_axis: an I2S/LJ serial driver pushes expected beats, a monitor checks them.
module tb_i2s_rx_axis;

  localparam int FIFO_DEPTH = 8;
  localparam int FRAME_LEN  = 4;
`ifdef I2S_RX_LJ_EN
  localparam int TB_D = 0;
`else
  localparam int TB_D = 1;
`endif

  logic        aclk;
  logic        aresetn;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        rx_enable;
  logic        ovf_clr;
  logic        ovf_sticky;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  logic [32:0] exp_q[$];
  int          n_checks;
  int          n_fail;
  int          frame_cnt;
  bit          phase_done;
  event        crit_ev;

  i2s_rx_axis #(.FIFO_DEPTH(FIFO_DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .i2s_bclk      (i2s_bclk),
    .i2s_lrclk     (i2s_lrclk),
    .i2s_sdata     (i2s_sdata),
    .rx_enable     (rx_enable),
    .ovf_clr       (ovf_clr),
    .ovf_sticky    (ovf_sticky),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  // clock / reset
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic do_reset(input int cycles);
    @(posedge aclk);
    #1 aresetn = 1'b0;
    repeat (cycles) @(posedge aclk);
    #1 aresetn = 1'b1;
    frame_cnt = 0;
  endtask

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // driver: one slot of nbits bclk periods (8 aclk each), data changes while bclk is low
  task automatic send_slot(input logic lr, input logic [15:0] w, input int nbits);
    int idx;
    for (int k = 0; k < nbits; k++) begin
      idx       = k - TB_D;
      i2s_bclk  = 1'b0;
      i2s_lrclk = lr;
      i2s_sdata = (idx >= 0 && idx <= 15) ? w[15-idx] : 1'b0;
      #40;
      i2s_bclk = 1'b1;
      if (lr && idx == 15) -> crit_ev;
      #40;
    end
  endtask

  task automatic send_pair(input logic [15:0] l, input logic [15:0] r, input bit expect_beat);
    if (expect_beat) begin
      exp_q.push_back({(frame_cnt == FRAME_LEN - 1), l, r});
      frame_cnt = (frame_cnt == FRAME_LEN - 1) ? 0 : frame_cnt + 1;
    end
    send_slot(1'b0, l, 32);
    send_slot(1'b1, r, 32);
  endtask

  task automatic set_ready(input logic v);
    @(posedge aclk);
    #1 m_axis_tready = v;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 3000) begin
      @(posedge aclk);
      n++;
    end
    n_checks++;
    if (n >= 3000) begin
      n_fail++;
      $display("FAIL %s drain_timeout pending=%0d expected=0", name, exp_q.size());
    end
  endtask

  // scoreboard monitor
  initial begin : monitor
    logic [32:0] got;
    logic [32:0] held;
    logic        hold_v;
    hold_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge aclk);
      got = {m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && !m_axis_tready) begin
        if (hold_v) check("stall_stable", got, held);
        held   = got;
        hold_v = 1'b1;
      end else begin
        hold_v = 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat_unexpected got=%h expected=none", got);
        end else begin
          check("beat", got, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    n_fail++;
    $display("FAIL watchdog got=timeout expected=finish pending=%0d", exp_q.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  logic [15:0] vec_l [7] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h7FFF, 16'hA5A5, 16'h0F0F, 16'h3C3C};
  logic [15:0] vec_r [7] = '{16'hFFFE, 16'h0001, 16'h0000, 16'h8001, 16'h5A5A, 16'hF0F0, 16'hC3C3};

  initial begin : stimulus
    n_checks      = 0;
    n_fail        = 0;
    frame_cnt     = 0;
    phase_done    = 1'b0;
    aresetn       = 1'b0;
    i2s_bclk      = 1'b0;
    i2s_lrclk     = 1'b0;
    i2s_sdata     = 1'b0;
    rx_enable     = 1'b1;
    ovf_clr       = 1'b0;
    m_axis_tready = 1'b1;
    do_reset(5);

    @(negedge aclk);
    check("rst_tvalid", {32'b0, m_axis_tvalid}, 33'd0);
    check("rst_tdata",  {1'b0, m_axis_tdata},   33'd0);
    check("rst_tlast",  {32'b0, m_axis_tlast},  33'd0);
    check("rst_ovf",    {32'b0, ovf_sticky},    33'd0);

    // stream begins in a right slot: that word has no left partner and is dropped
    send_slot(1'b1, 16'h5555, 32);

    // first pair with latency measured from the right idx-15 bclk rise
    fork
      send_pair(16'h1234, 16'hABCD, 1'b1);
      begin
        @(crit_ev);
        repeat (3) @(posedge aclk);
        #1 check("lat_n2_tvalid", {32'b0, m_axis_tvalid}, 33'd0);
        @(posedge aclk);
        #1 check("lat_n3_tvalid", {32'b0, m_axis_tvalid}, 33'd1);
      end
    join
    wait_drain("first_pair");

    // seven more pairs with irregular back-pressure; tlast on beats 4 and 8
    phase_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 7; i++) send_pair(vec_l[i], vec_r[i], 1'b1);
        phase_done = 1'b1;
      end
      begin
        while (!phase_done) begin
          @(posedge aclk);
          #1 m_axis_tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    set_ready(1'b1);
    wait_drain("frame_pairs");

    // overflow: ten pairs into a stalled FIFO, only the first eight are kept
    set_ready(1'b0);
    for (int i = 0; i < 10; i++)
      send_pair(16'h1000 + 16'(i), 16'h2000 + 16'(i), (i < FIFO_DEPTH));
    @(negedge aclk);
    check("ovf_set",    {32'b0, ovf_sticky},    33'd1);
    check("ovf_tvalid", {32'b0, m_axis_tvalid}, 33'd1);
    @(posedge aclk);
    #1 ovf_clr = 1'b1;
    @(posedge aclk);
    #1 ovf_clr = 1'b0;
    @(negedge aclk);
    check("ovf_cleared", {32'b0, ovf_sticky}, 33'd0);
    set_ready(1'b1);
    wait_drain("ovf_drain");
    for (int i = 0; i < 4; i++) send_pair(16'h4440 + 16'(i), 16'h8880 + 16'(i), 1'b1);
    wait_drain("post_ovf_frame");

    // short 12-bit left slot: that frame produces nothing
    send_slot(1'b0, 16'h0F0F, 12);
    send_slot(1'b1, 16'h7777, 32);
    send_pair(16'h2468, 16'h1357, 1'b1);
    wait_drain("short_slot");

    // receive disabled for one frame
    rx_enable = 1'b0;
    send_pair(16'h1111, 16'h2222, 1'b0);
    rx_enable = 1'b1;
    send_pair(16'h3333, 16'h4444, 1'b1);
    wait_drain("rx_enable");

    // reset in the middle of a left slot
    send_slot(1'b0, 16'hDEAD, 10);
    do_reset(3);
    @(negedge aclk);
    check("midrst_tvalid", {32'b0, m_axis_tvalid}, 33'd0);
    check("midrst_ovf",    {32'b0, ovf_sticky},    33'd0);
    send_slot(1'b1, 16'hBEEF, 32);
    send_pair(16'hCAFE, 16'h0042, 1'b1);
    wait_drain("mid_reset");

    repeat (20) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
